// File: rtl/mcu_sequencer_if.sv
// Instruction handshake plus register-file and ALU buses of the MCU sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface mcu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] rf_a_add;
  logic [ADDR_W-1:0] rf_b_add;
  logic [ADDR_W-1:0] rf_d_add;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  modport master (
    input  instr_valid, instr, rf_data_a, rf_data_b, alu_result,
    output instr_ready, rf_a_add, rf_b_add, rf_d_add, rf_wdata, rf_we,
           alu_op, alu_a, alu_b
  );

  modport slave (
    output instr_valid, instr, rf_data_a, rf_data_b, alu_result,
    input  instr_ready, rf_a_add, rf_b_add, rf_d_add, rf_wdata, rf_we,
           alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/mcu_sequencer.sv
// Multicycle sequencer: IDLE -> READ -> EXEC -> WB for ALU/MOV, IDLE -> WB for LDI.
// Owns the register file write port; tracks zero flag, sticky error and retire count.
module mcu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mcu_sequencer_if.master  bus,
  output logic             zero_flag,
  output logic             err,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_rd;
  logic              r_mov;
  logic [ADDR_W-1:0] r_rf_a_add;
  logic [ADDR_W-1:0] r_rf_b_add;
  logic [ADDR_W-1:0] r_rf_d_add;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_rf_we;
  logic [2:0]        r_alu_op;
  logic              r_zero;
  logic              r_err;
  logic              r_halted;
  logic [CNT_W-1:0]  r_retired;

  logic [3:0]        w_opc;
  logic [ADDR_W-1:0] w_rd;

  assign w_opc = bus.instr[15:12];
  assign w_rd  = bus.instr[11:9];

  // Sequencer state, latched instruction fields and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd       <= {ADDR_W{1'b0}};
      r_mov      <= 1'b0;
      r_rf_a_add <= {ADDR_W{1'b0}};
      r_rf_b_add <= {ADDR_W{1'b0}};
      r_rf_d_add <= {ADDR_W{1'b0}};
      r_rf_wdata <= {DATA_W{1'b0}};
      r_rf_we    <= 1'b0;
      r_alu_op   <= 3'd0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
      r_halted   <= 1'b0;
      r_retired  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_rd       <= w_rd;
            r_mov      <= (w_opc == 4'h6);
            r_rf_a_add <= bus.instr[8:6];
            r_rf_b_add <= bus.instr[5:3];
            r_alu_op   <= w_opc[2:0];
            case (w_opc)
              4'h0: r_retired <= r_retired + CNT_W'(1);
              4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: r_state <= S_READ;
              4'h7: begin
                // LDI skips the register read and goes straight to write-back.
                r_rf_d_add <= w_rd;
                r_rf_wdata <= DATA_W'(bus.instr[7:0]);
                r_rf_we    <= (w_rd != {ADDR_W{1'b0}});
                r_state    <= S_WB;
              end
              4'hF: begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end
              default: r_err <= 1'b1;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: r_state <= S_EXEC;
        S_EXEC: begin
          r_rf_d_add <= r_rd;
          r_rf_wdata <= r_mov ? bus.rf_data_a : bus.alu_result;
          r_rf_we    <= (r_rd != {ADDR_W{1'b0}});
          r_state    <= S_WB;
        end
        S_WB: begin
          // Flag tracks the computed value even when the write to r0 is dropped.
          r_rf_we   <= 1'b0;
          r_zero    <= (r_rf_wdata == {DATA_W{1'b0}});
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= S_IDLE;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.rf_a_add    = r_rf_a_add;
  assign bus.rf_b_add    = r_rf_b_add;
  assign bus.rf_d_add    = r_rf_d_add;
  assign bus.rf_wdata    = r_rf_wdata;
  assign bus.rf_we       = r_rf_we;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_a       = bus.rf_data_a;
  assign bus.alu_b       = bus.rf_data_b;
  assign zero_flag       = r_zero;
  assign err             = r_err;
  assign halted          = r_halted;
  assign retired         = r_retired;
endmodule

// File: tb/tb_mcu_sequencer.sv
// Directed bench for mcu_sequencer with a registered-read register file and ALU model.
module tb_mcu_sequencer;
  logic        clk;
  logic        rst_n;
  logic        zero_flag;
  logic        err;
  logic        halted;
  logic [15:0] retired;
  int          n_checks;
  int          n_fail;

  mcu_sequencer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  mcu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .zero_flag (zero_flag),
    .err       (err),
    .halted    (halted),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous write, registered read, r0 reads as zero.
  logic [7:0] mem [0:7] = '{8'h00, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
  always @(posedge clk) begin
    if (bus.rf_we && bus.rf_d_add != 3'd0) mem[bus.rf_d_add] <= bus.rf_wdata;
    bus.rf_data_a <= (bus.rf_a_add == 3'd0) ? 8'h00 : mem[bus.rf_a_add];
    bus.rf_data_b <= (bus.rf_b_add == 3'd0) ? 8'h00 : mem[bus.rf_b_add];
  end

  always_comb begin
    case (bus.alu_op)
      3'd1:    bus.alu_result = bus.alu_a + bus.alu_b;
      3'd2:    bus.alu_result = bus.alu_a - bus.alu_b;
      3'd3:    bus.alu_result = bus.alu_a & bus.alu_b;
      3'd4:    bus.alu_result = bus.alu_a | bus.alu_b;
      3'd5:    bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction; returns #1 after the accepting edge with valid dropped.
  task automatic send(input logic [15:0] ins);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'hFFFF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);

    // LDI r1,0x05: write-back one edge after acceptance
    send(16'h7205);
    chk("ldi_we", 32'(bus.rf_we), 32'd1);
    chk("ldi_dadd", 32'(bus.rf_d_add), 32'd1);
    chk("ldi_wdata", 32'(bus.rf_wdata), 32'h05);
    chk("ldi_ready_busy", 32'(bus.instr_ready), 32'd0);
    step();
    chk("ldi_we_drop", 32'(bus.rf_we), 32'd0);
    chk("ldi_retired", 32'(retired), 32'd1);
    chk("ldi_r1", 32'(mem[1]), 32'h05);

    // LDI r2,0x03; ADD r3,r1,r2
    send(16'h7403);
    step();
    send(16'h1650);
    chk("add_a_add", 32'(bus.rf_a_add), 32'd1);
    chk("add_b_add", 32'(bus.rf_b_add), 32'd2);
    chk("add_we_read", 32'(bus.rf_we), 32'd0);
    step();
    chk("add_we_exec", 32'(bus.rf_we), 32'd0);
    step();
    chk("add_we", 32'(bus.rf_we), 32'd1);
    chk("add_dadd", 32'(bus.rf_d_add), 32'd3);
    chk("add_wdata", 32'(bus.rf_wdata), 32'h08);
    step();
    chk("add_r3", 32'(mem[3]), 32'h08);
    chk("add_zero", 32'(zero_flag), 32'd0);
    chk("add_retired", 32'(retired), 32'd3);

    // SUB r4,r1,r1 then immediate MOV r5,r4 (r4 starts at 0x54)
    send(16'h2848);
    step();
    step();
    chk("sub_wdata", 32'(bus.rf_wdata), 32'h00);
    step();
    chk("sub_zero", 32'(zero_flag), 32'd1);
    chk("sub_r4", 32'(mem[4]), 32'h00);
    send(16'h6B00);
    step();
    step();
    chk("mov_we", 32'(bus.rf_we), 32'd1);
    chk("mov_dadd", 32'(bus.rf_d_add), 32'd5);
    chk("mov_wdata", 32'(bus.rf_wdata), 32'h00);
    step();
    chk("mov_r5", 32'(mem[5]), 32'h00);
    chk("mov_retired", 32'(retired), 32'd5);

    // LDI r0,0xAA: no write, flag clears, counted
    send(16'h70AA);
    chk("ldi0_we", 32'(bus.rf_we), 32'd0);
    step();
    chk("ldi0_zero", 32'(zero_flag), 32'd0);
    chk("ldi0_retired", 32'(retired), 32'd6);

    // Illegal opcode 0x9
    send(16'h9E00);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_ready", 32'(bus.instr_ready), 32'd1);
    chk("ill_we", 32'(bus.rf_we), 32'd0);
    chk("ill_retired", 32'(retired), 32'd6);

    // NOP
    send(16'h0000);
    chk("nop_retired", 32'(retired), 32'd7);
    chk("nop_ready", 32'(bus.instr_ready), 32'd1);

    // HALT with valid held high afterwards
    send(16'hF000);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h7207;
    chk("halt_halted", 32'(halted), 32'd1);
    repeat (5) step();
    chk("halt_ready", 32'(bus.instr_ready), 32'd0);
    chk("halt_we", 32'(bus.rf_we), 32'd0);
    chk("halt_retired", 32'(retired), 32'd7);
    chk("halt_r1", 32'(mem[1]), 32'h05);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_err", 32'(err), 32'd0);
    chk("hrst_zero", 32'(zero_flag), 32'd0);
    chk("hrst_retired", 32'(retired), 32'd0);
    chk("hrst_wdata", 32'(bus.rf_wdata), 32'd0);
    chk("hrst_aluop", 32'(bus.alu_op), 32'd0);
    chk("hrst_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during EXEC of ADD r6,r1,r2
    send(16'h7205);
    step();
    send(16'h7403);
    step();
    send(16'h1C50);
    step();
    rst_n = 1'b0;
    #1;
    chk("exrst_we", 32'(bus.rf_we), 32'd0);
    chk("exrst_retired", 32'(retired), 32'd0);
    chk("exrst_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WB of the same ADD: write must not land
    send(16'h1C50);
    step();
    step();
    chk("wbrst_we_before", 32'(bus.rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wbrst_we", 32'(bus.rf_we), 32'd0);
    step();
    chk("wbrst_r6", 32'(mem[6]), 32'h56);
    chk("wbrst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
- Multicycle instruction sequencer for the 8-bit MCU datapath.
- Accepts one 16-bit instruction at a time over a valid/ready handshake.
- Drives the 8x8 register file's read addresses, write address, write data and write enable, and the operand/opcode lines of the external combinational ALU.
- Owns the register file's single write port. Tracks a zero flag, a sticky illegal-opcode error and a retired-instruction count.

Parameters:
DATA_W, 8, register/ALU data width
ADDR_W, 3, register address width (2**ADDR_W registers, r0 reads as zero)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept; equals (state==IDLE)
instr  in  16  [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [7:0] imm (LDI only)
rf_a_add  out  ADDR_W  register file read address A
rf_b_add  out  ADDR_W  register file read address B
rf_d_add  out  ADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
rf_we  out  1  register file write enable
rf_data_a  in  DATA_W  register file read data A (registered, valid one edge after address)
rf_data_b  in  DATA_W  register file read data B
alu_op  out  3  ALU function = opcode[2:0]
alu_a  out  DATA_W  ALU operand A (= rf_data_a)
alu_b  out  DATA_W  ALU operand B (= rf_data_b)
alu_result  in  DATA_W  combinational ALU result
zero_flag  out  1  set when last written value == 0
err  out  1  sticky illegal-opcode flag
halted  out  1  HALT executed
retired  out  CNT_W  count of instructions completing WB or NOP

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - rf_we, rf_a_add, rf_b_add, rf_d_add, rf_wdata, alu_op = 0.
  - zero_flag, err, halted = 0; retired = 0.
  - Reset mid-instruction abandons it with no write, including rf_we dropping while in WB.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV (rd<=ra), 7 LDI (rd<=imm), F HALT, 8-E illegal.
- States and transitions:
  - IDLE: instr_ready=1. On instr_valid, latch instr.
    - ALU/MOV -> READ.
    - LDI -> WB.
    - NOP -> IDLE, retired+1.
    - illegal -> IDLE, err<=1, not counted.
    - HALT -> HALT.
  - READ: rf_a_add=ra, rf_b_add=rb held. -> EXEC.
  - EXEC: rf_data_a/b valid. Capture result register = alu_result (ALU ops) or rf_data_a (MOV). -> WB.
  - WB:
    - rf_d_add=rd, rf_wdata=result, rf_we=1 for exactly this cycle.
    - Suppress rf_we when rd==0.
    - zero_flag<=(result==0), updated even when rd==0.
    - retired+1 (wraps at 2**CNT_W).
    - -> IDLE.
  - HALT: instr_ready=0, halted=1. Leaves only on reset.
- Latency from accepting edge to write edge:
  - ALU/MOV: 3 edges, 4 cycles per instruction.
  - LDI: 1 edge, 2 cycles per instruction.
- rf_we is a registered output, high only in WB.
- Read-after-write needs no stall: the WB write lands before the next READ sample.
- Addresses in READ come from the latched instruction. instr may change after acceptance without effect.
- instr_valid is ignored outside IDLE.
- No arithmetic widening: result is DATA_W bits, and carry is owned by the ALU.

Test Plan:
- Reset, then LDI r1,0x05 -> instr_ready=1 first cycle; WB at +1 edge: rf_d_add=1, rf_wdata=0x05, rf_we=1 for 1 cycle; retired=1.
- LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 (bench RF+ALU model) -> READ drives a=1,b=2; write r3=0x08 three edges after acceptance; zero_flag=0; retired=3.
- SUB r4,r1,r1 -> r4=0x00, zero_flag=1. Immediate MOV r5,r4 reads 0x00, with no stall inserted.
- LDI r0,0xAA -> rf_we stays 0, zero_flag=0, retired increments. Opcode 0x9 -> err=1, no write, retired unchanged, instr_ready back in 1 cycle.
- HALT then instr_valid held high -> halted=1, instr_ready=0 indefinitely. Assert rst_n=0 -> all outputs 0, state IDLE.
- Assert rst_n low during EXEC, then during WB of ADD -> rf_we=0 immediately (asynchronous), no write to rd, retired=0.
